// File: rtl/count_monitor.sv
// count_monitor: checks an up-counter's (enable, count) stream against a
// one-cycle prediction, acquires lock, and counts errors and wraps.
module count_monitor #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [ERRW-1:0]  err_count,
  output logic [ERRW-1:0]  wrap_count,
  output logic [WIDTH-1:0] expected
);

  localparam int RW = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [WIDTH-1:0] prev_cnt_q;
  logic             prev_en_q;
  logic [WIDTH-1:0] exp_q;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [ERRW-1:0]  errc_q, errc_d;
  logic [ERRW-1:0]  wrap_q, wrap_d;

  logic match;
  logic wrap_hit;

  // exp_q always equals prev_cnt_q + prev_en_q
  assign match    = (count_in == exp_q);
  assign wrap_hit = prev_en_q && (&prev_cnt_q)
                 && (count_in == '0);

  // Next-state, error and counter update logic
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    errc_d   = errc_q;
    wrap_d   = wrap_q;
    if (err_clr) begin
      state_d  = UNLOCKED;
      run_d    = '0;
      sticky_d = 1'b0;
      errc_d   = '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          state_d = ACQUIRE;
          run_d   = '0;
        end
        ACQUIRE: begin
          if (!match) begin
            run_d = '0;
          end else if (run_q == RW'(LOCK_LEN - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        LOCKED: begin
          if (!match) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
            state_d  = ACQUIRE;
            run_d    = '0;
            if (errc_q != '1) errc_d = errc_q + ERRW'(1);
          end else if (wrap_hit && wrap_q != '1) begin
            wrap_d = wrap_q + ERRW'(1);
          end
        end
        default: begin
          state_d = UNLOCKED;
          run_d   = '0;
        end
      endcase
    end
  end

  // State and sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      run_q      <= '0;
      prev_cnt_q <= '0;
      prev_en_q  <= 1'b0;
      exp_q      <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      errc_q     <= '0;
      wrap_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_cnt_q <= count_in;
      prev_en_q  <= enable;
      exp_q      <= count_in + WIDTH'(enable);
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      errc_q     <= errc_d;
      wrap_q     <= wrap_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = errc_q;
  assign wrap_count = wrap_q;
  assign expected   = exp_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed counter streams with hand-computed expectations,
// checked through a tagged scoreboard queue by a negedge monitor.
module tb_count_monitor;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] count_in;
  logic       err_clr;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [1:0] err_count;
  logic [1:0] wrap_count;
  logic [7:0] expected;

  count_monitor #(
    .WIDTH(8), .LOCK_LEN(4), .ERRW(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .count_in(count_in),
    .err_clr(err_clr),
    .locked(locked),
    .err(err),
    .err_sticky(err_sticky),
    .err_count(err_count),
    .wrap_count(wrap_count),
    .expected(expected)
  );

  typedef struct {
    int         tag;
    string      nm;
    logic       lk;
    logic       er;
    logic       st;
    logic [1:0] ec;
    logic [1:0] wc;
    logic [7:0] ex;
  } item_t;

  item_t q[$];
  item_t it;
  int    cyc;
  int    ntests;
  int    nfail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every item tagged for the current cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tag == cyc) begin
      it = q.pop_front();
      ntests++;
      if (locked !== it.lk || err !== it.er ||
          err_sticky !== it.st || err_count !== it.ec ||
          wrap_count !== it.wc || expected !== it.ex) begin
        nfail++;
        $display("FAIL %s: got lk=%0b er=%0b st=%0b ec=%0d wc=%0d ex=%02h want lk=%0b er=%0b st=%0b ec=%0d wc=%0d ex=%02h",
                 it.nm, locked, err, err_sticky, err_count,
                 wrap_count, expected, it.lk, it.er, it.st,
                 it.ec, it.wc, it.ex);
      end
    end
  end

  task automatic drv(input logic en, input logic [7:0] c,
                     input logic clr);
    enable   = en;
    count_in = c;
    err_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic lk,
                     input logic er, input logic st,
                     input logic [1:0] ec, input logic [1:0] wc,
                     input logic [7:0] ex);
    item_t e;
    e.tag = cyc;
    e.nm  = nm;
    e.lk  = lk;
    e.er  = er;
    e.st  = st;
    e.ec  = ec;
    e.wc  = wc;
    e.ex  = ex;
    q.push_back(e);
  endtask

  int ec_tab[5] = '{1, 2, 3, 3, 3};
  int c;

  initial begin
    cyc      = 0;
    ntests   = 0;
    nfail    = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    count_in = 8'h00;
    err_clr  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 0, 0, 0, 0, 0, 8'h00);
    #4;
    rst_n = 1'b1;

    // good counter from 0: lock after first sample + LOCK_LEN
    for (int k = 0; k <= 4; k++) begin
      drv(1'b1, 8'(k), 1'b0);
      if (k == 3) chk("acq_not_locked", 0, 0, 0, 0, 0, 8'h04);
      if (k == 4) chk("lock_time", 1, 0, 0, 0, 0, 8'h05);
    end
    drv(1'b1, 8'h05, 1'b0);
    drv(1'b1, 8'h06, 1'b0);

    // enable low, count held at 7
    for (int k = 0; k < 5; k++) drv(1'b0, 8'h07, 1'b0);
    chk("hold", 1, 0, 0, 0, 0, 8'h07);
    drv(1'b1, 8'h07, 1'b0);
    drv(1'b1, 8'h08, 1'b0);
    chk("reenable", 1, 0, 0, 0, 0, 8'h09);

    // 0x12 -> 0x15 skip
    for (int k = 9; k <= 8'h12; k++) drv(1'b1, 8'(k), 1'b0);
    drv(1'b1, 8'h15, 1'b0);
    chk("skip_err", 0, 1, 1, 1, 0, 8'h16);
    drv(1'b1, 8'h16, 1'b0);
    chk("err_1cyc", 0, 0, 1, 1, 0, 8'h17);
    drv(1'b1, 8'h17, 1'b0);
    drv(1'b1, 8'h18, 1'b0);
    chk("acq_3", 0, 0, 1, 1, 0, 8'h19);
    drv(1'b1, 8'h19, 1'b0);
    chk("relock", 1, 0, 1, 1, 0, 8'h1A);

    // wrap 0xFE -> 0xFF -> 0x00
    for (int k = 8'h1A; k <= 8'hFF; k++) drv(1'b1, 8'(k), 1'b0);
    chk("pre_wrap", 1, 0, 1, 1, 0, 8'h00);
    drv(1'b1, 8'h00, 1'b0);
    chk("wrap", 1, 0, 1, 1, 1, 8'h01);

    // counter reset at 0x40
    for (int k = 1; k <= 8'h40; k++) drv(1'b1, 8'(k), 1'b0);
    drv(1'b1, 8'h00, 1'b0);
    chk("cnt_reset", 0, 1, 1, 2, 1, 8'h01);
    for (int k = 1; k <= 4; k++) drv(1'b1, 8'(k), 1'b0);
    chk("relock2", 1, 0, 1, 2, 1, 8'h05);
    for (int k = 5; k <= 8; k++) drv(1'b1, 8'(k), 1'b0);

    // counter reset together with err_clr
    drv(1'b1, 8'h00, 1'b1);
    chk("clr_wins", 0, 0, 0, 0, 1, 8'h01);
    for (int k = 1; k <= 4; k++) drv(1'b1, 8'(k), 1'b0);
    chk("acq_after_clr", 0, 0, 0, 0, 1, 8'h05);
    drv(1'b1, 8'h05, 1'b0);
    chk("relock3", 1, 0, 0, 0, 1, 8'h06);

    // five mismatches, err_count saturates at 3
    c = 6;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'(c + 1), 1'b0);
      chk($sformatf("sat_err%0d", i), 0, 1, 1,
          2'(ec_tab[i]), 1, 8'(c + 2));
      for (int k = 2; k <= 5; k++) drv(1'b1, 8'(c + k), 1'b0);
      c = c + 6;
    end
    chk("sat_relock", 1, 0, 1, 3, 1, 8'(c));

    // async reset mid-cycle
    drv(1'b1, 8'(c), 1'b0);
    #2;
    rst_n = 1'b0;
    chk("async_rst", 0, 0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d pending want 0", q.size());
      nfail = nfail + q.size();
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
